hazard_bypass_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the 5-stage pipeline, sitting beside the DX/XM/MW latches.
- Selects ALU operand sources (regfile / XM / MW) and MW-to-XM store-data bypass.
- Detects load-use hazards and generates stall.
- Tracks outstanding long-latency multdiv destinations in an in-order pending FIFO and stalls DX readers of unwritten results.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_bypass_unit_if.sv | 47 ++++
 rtl/md_pending_fifo.sv | 89 ++++++++
 rtl/hazard_bypass_unit.sv | 112 +++++++++++
 tb/tb_hazard_bypass_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the forwarding / hazard unit.
//   sel_t    - 2-bit ALU operand source select
//   SEL_RF   - operand from register file
//   SEL_XM   - operand forwarded from the XM latch
//   SEL_MW   - operand forwarded from the MW latch
//   ZERO_REG - hard-wired zero register, never forwarded or hazarded
package hazard_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_RF = 2'd0;
    localparam sel_t SEL_XM = 2'd1;
    localparam sel_t SEL_MW = 2'd2;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_bypass_unit_if.sv
// hazard_bypass_unit_if: pipeline-side signal bundle for hazard_bypass_unit.
//   Inputs to the unit : dx_rs1/2, dx_use_rs1/2, xm_rd, xm_we, xm_is_load, xm_is_store,
//                        xm_rs2, mw_rd, mw_we, md_start, md_rd, md_done
//   Outputs of the unit: sel_a, sel_b, dmem_sel, stall, md_full, md_err
// master = pipeline side, slave = hazard_bypass_unit.
interface hazard_bypass_unit_if #(
    parameter int unsigned REG_W = 5
);
    import hazard_pkg::*;

    logic [REG_W-1:0] dx_rs1;
    logic [REG_W-1:0] dx_rs2;
    logic             dx_use_rs1;
    logic             dx_use_rs2;
    logic [REG_W-1:0] xm_rd;
    logic             xm_we;
    logic             xm_is_load;
    logic             xm_is_store;
    logic [REG_W-1:0] xm_rs2;
    logic [REG_W-1:0] mw_rd;
    logic             mw_we;
    logic             md_start;
    logic [REG_W-1:0] md_rd;
    logic             md_done;

    sel_t             sel_a;
    sel_t             sel_b;
    logic             dmem_sel;
    logic             stall;
    logic             md_full;
    logic             md_err;

    modport master (
        output dx_rs1, dx_rs2, dx_use_rs1, dx_use_rs2,
        output xm_rd, xm_we, xm_is_load, xm_is_store, xm_rs2,
        output mw_rd, mw_we, md_start, md_rd, md_done,
        input  sel_a, sel_b, dmem_sel, stall, md_full, md_err
    );

    modport slave (
        input  dx_rs1, dx_rs2, dx_use_rs1, dx_use_rs2,
        input  xm_rd, xm_we, xm_is_load, xm_is_store, xm_rs2,
        input  mw_rd, mw_we, md_start, md_rd, md_done,
        output sel_a, sel_b, dmem_sel, stall, md_full, md_err
    );

endinterface

// File: rtl/md_pending_fifo.sv
// md_pending_fifo: in-order list of destination registers of outstanding multdiv ops.
//   clock, reset          - clock, synchronous active-high reset
//   push_i, push_rd_i     - append a destination (caller guarantees no push into a full
//                           FIFO unless done_i pops in the same cycle)
//   done_i                - oldest result is being written back; pops when non-empty
//   lkN_vld_i, lkN_src_i  - lookup ports: does any valid entry hold lkN_src_i?
//   lkN_hit_o             - lookup result; the head is excluded while it is popping
//   full_o                - occupancy == MD_DEPTH
//   err_o                 - sticky: done_i seen with the FIFO empty
module md_pending_fifo #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MD_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [REG_W-1:0] push_rd_i,
    input  logic             done_i,
    input  logic             lk0_vld_i,
    input  logic [REG_W-1:0] lk0_src_i,
    output logic             lk0_hit_o,
    input  logic             lk1_vld_i,
    input  logic [REG_W-1:0] lk1_src_i,
    output logic             lk1_hit_o,
    output logic             full_o,
    output logic             err_o
);

    localparam int unsigned PtrW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(MD_DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [REG_W-1:0] mem_q [MD_DEPTH];
    ptr_t             head_q;
    ptr_t             tail_q;
    cnt_t             count_q;
    logic             err_q;
    logic             pop;
    ptr_t             scan_idx;

    // Wrap explicitly so non power-of-two depths work.
    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(MD_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign pop    = done_i && (count_q != '0);
    assign full_o = (count_q == cnt_t'(MD_DEPTH));
    assign err_o  = err_q;

    // Walk entries oldest-first; position 0 is the head, dropped when it retires this cycle
    // because its value is already on the MW write port.
    always_comb begin
        lk0_hit_o = 1'b0;
        lk1_hit_o = 1'b0;
        scan_idx  = head_q;
        for (int k = 0; k < int'(MD_DEPTH); k++) begin
            if ((k < int'(count_q)) && !((k == 0) && pop)) begin
                if (lk0_vld_i && (mem_q[scan_idx] == lk0_src_i)) lk0_hit_o = 1'b1;
                if (lk1_vld_i && (mem_q[scan_idx] == lk1_src_i)) lk1_hit_o = 1'b1;
            end
            scan_idx = ptr_inc(scan_idx);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push_i) tail_q <= ptr_inc(tail_q);
            if (pop)    head_q <= ptr_inc(head_q);
            case ({push_i, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
            if (done_i && (count_q == '0)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[tail_q] <= push_rd_i;
    end

endmodule

// File: rtl/hazard_bypass_unit.sv
// hazard_bypass_unit: operand forwarding, load-use and multdiv hazard detection for the
// 5-stage pipeline.
//   clock, reset  - pipeline clock, synchronous active-high reset
//   bus (slave)   - DX/XM/MW/multdiv inputs; sel_a, sel_b, dmem_sel, stall, md_full,
//                   md_err outputs (see hazard_bypass_unit_if)
//   stat_stall_cnt, stat_fwd_cnt - saturating statistics counters, present only when
//                   HAZARD_BYPASS_STATS_EN is defined
module hazard_bypass_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MD_DEPTH = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_bypass_unit_if.slave  bus
`ifdef HAZARD_BYPASS_STATS_EN
    ,
    output logic [CNT_W-1:0]     stat_stall_cnt,
    output logic [CNT_W-1:0]     stat_fwd_cnt
`endif
);

    localparam logic [REG_W-1:0] Zero = REG_W'(ZERO_REG);

    logic xm_m_a, xm_m_b, mw_m_a, mw_m_b;
    logic lk_a_vld, lk_b_vld, pend_a, pend_b;
    logic load_use, stall_full, stall, push, md_full;
    sel_t sel_a, sel_b;
    logic dmem_sel;

    assign xm_m_a = bus.xm_we && (bus.xm_rd == bus.dx_rs1) && (bus.dx_rs1 != Zero);
    assign xm_m_b = bus.xm_we && (bus.xm_rd == bus.dx_rs2) && (bus.dx_rs2 != Zero);
    assign mw_m_a = bus.mw_we && (bus.mw_rd == bus.dx_rs1) && (bus.dx_rs1 != Zero);
    assign mw_m_b = bus.mw_we && (bus.mw_rd == bus.dx_rs2) && (bus.dx_rs2 != Zero);

    // A load in XM has no data yet, so it is skipped and MW (older) may still forward.
    always_comb begin
        sel_a = SEL_RF;
        if (bus.dx_use_rs1) begin
            if (xm_m_a && !bus.xm_is_load) sel_a = SEL_XM;
            else if (mw_m_a)               sel_a = SEL_MW;
        end
        sel_b = SEL_RF;
        if (bus.dx_use_rs2) begin
            if (xm_m_b && !bus.xm_is_load) sel_b = SEL_XM;
            else if (mw_m_b)               sel_b = SEL_MW;
        end
    end

    assign dmem_sel = bus.xm_is_store && bus.mw_we && (bus.mw_rd == bus.xm_rs2) &&
                      (bus.xm_rs2 != Zero);

    assign load_use = bus.xm_is_load &&
                      ((bus.dx_use_rs1 && xm_m_a) || (bus.dx_use_rs2 && xm_m_b));

    assign lk_a_vld = bus.dx_use_rs1 && (bus.dx_rs1 != Zero);
    assign lk_b_vld = bus.dx_use_rs2 && (bus.dx_rs2 != Zero);

    // A full FIFO can still accept when the oldest entry retires in the same cycle.
    assign stall_full = bus.md_start && md_full && !bus.md_done;
    assign stall      = load_use || pend_a || pend_b || stall_full;
    // A stalled multdiv is re-presented next cycle, so it must not be recorded now.
    assign push       = bus.md_start && !stall;

    md_pending_fifo #(
        .REG_W    (REG_W),
        .MD_DEPTH (MD_DEPTH)
    ) u_md_pending_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push),
        .push_rd_i (bus.md_rd),
        .done_i    (bus.md_done),
        .lk0_vld_i (lk_a_vld),
        .lk0_src_i (bus.dx_rs1),
        .lk0_hit_o (pend_a),
        .lk1_vld_i (lk_b_vld),
        .lk1_src_i (bus.dx_rs2),
        .lk1_hit_o (pend_b),
        .full_o    (md_full),
        .err_o     (bus.md_err)
    );

    assign bus.sel_a    = sel_a;
    assign bus.sel_b    = sel_b;
    assign bus.dmem_sel = dmem_sel;
    assign bus.stall    = stall;
    assign bus.md_full  = md_full;

`ifdef HAZARD_BYPASS_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
    logic             fwd_any;

    assign fwd_any = (sel_a != SEL_RF) || (sel_b != SEL_RF) || dmem_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (fwd_any && (fwd_cnt_q != '1))  fwd_cnt_q   <= fwd_cnt_q + CNT_W'(1);
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_bypass_unit.sv
module tb_hazard_bypass_unit;
    import hazard_pkg::*;

    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_bypass_unit_if #(.REG_W(5)) bus ();

    hazard_bypass_unit #(
        .REG_W    (5),
        .MD_DEPTH (DEPTH),
        .CNT_W    (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] xm_rd;
        logic       xm_we, xm_ld, xm_st;
        logic [4:0] xm_rs2, mw_rd;
        logic       mw_we;
        logic [1:0] e_sa, e_sb;
        logic       e_dm, e_st;
    } vec_t;

    vec_t vecs[11];

    // Reference model state: pending multdiv destinations, oldest first.
    int q[$];
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.dx_rs1 = '0; bus.dx_rs2 = '0; bus.dx_use_rs1 = 0; bus.dx_use_rs2 = 0;
        bus.xm_rd = '0; bus.xm_we = 0; bus.xm_is_load = 0; bus.xm_is_store = 0;
        bus.xm_rs2 = '0; bus.mw_rd = '0; bus.mw_we = 0;
        bus.md_start = 0; bus.md_rd = '0; bus.md_done = 0;
    endtask

    function automatic int ref_sel(bit u, int src, bit ld);
        if (!u || src == 0) return 0;
        if (bus.xm_we && int'(bus.xm_rd) == src && !ld) return 1;
        if (bus.mw_we && int'(bus.mw_rd) == src) return 2;
        return 0;
    endfunction

    function automatic bit ref_pend(bit u, int src, bit done);
        if (!u || src == 0) return 0;
        for (int i = (done ? 1 : 0); i < q.size(); i++)
            if (q[i] == src) return 1;
        return 0;
    endfunction

    initial begin
        vecs[0]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1,
                     2'd1, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0,
                     2'd0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 1'b1,
                     2'd2, 2'd0, 1'b0, 1'b1};
        vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0,
                     2'd0, 2'd0, 1'b0, 1'b1};
        vecs[4]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1,
                     2'd0, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 1'b1,
                     2'd0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 1'b1,
                     2'd2, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1,
                     2'd0, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1,
                     2'd0, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0,
                     2'd0, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{5'd7, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1,
                     2'd2, 2'd1, 1'b1, 1'b0};

        clear_in();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        check("reset_stall", bus.stall, 0);
        check("reset_md_full", bus.md_full, 0);
        check("reset_md_err", bus.md_err, 0);
        check("reset_sel_a", bus.sel_a, 0);

        // Combinational forwarding table, FIFO empty.
        foreach (vecs[i]) begin
            bus.dx_rs1 = vecs[i].rs1; bus.dx_rs2 = vecs[i].rs2;
            bus.dx_use_rs1 = vecs[i].u1; bus.dx_use_rs2 = vecs[i].u2;
            bus.xm_rd = vecs[i].xm_rd; bus.xm_we = vecs[i].xm_we;
            bus.xm_is_load = vecs[i].xm_ld; bus.xm_is_store = vecs[i].xm_st;
            bus.xm_rs2 = vecs[i].xm_rs2; bus.mw_rd = vecs[i].mw_rd; bus.mw_we = vecs[i].mw_we;
            #1;
            check($sformatf("vec%0d_sel_a", i), bus.sel_a, vecs[i].e_sa);
            check($sformatf("vec%0d_sel_b", i), bus.sel_b, vecs[i].e_sb);
            check($sformatf("vec%0d_dmem_sel", i), bus.dmem_sel, vecs[i].e_dm);
            check($sformatf("vec%0d_stall", i), bus.stall, vecs[i].e_st);
            tick();
        end

        // Load-use: one stall, then MW forwarding.
        clear_in();
        bus.xm_is_load = 1; bus.xm_we = 1; bus.xm_rd = 5'd5;
        bus.dx_rs2 = 5'd5; bus.dx_use_rs2 = 1;
        #1;
        check("lu_stall", bus.stall, 1);
        tick();
        bus.xm_we = 0; bus.xm_is_load = 0; bus.mw_rd = 5'd5; bus.mw_we = 1;
        #1;
        check("lu_after_sel_b", bus.sel_b, 2);
        check("lu_after_stall", bus.stall, 0);
        tick();

        // Single multdiv: reader stalls until writeback.
        clear_in();
        bus.md_start = 1; bus.md_rd = 5'd7;
        #1;
        check("md_issue_stall", bus.stall, 0);
        tick();
        bus.md_start = 0; bus.dx_rs1 = 5'd7; bus.dx_use_rs1 = 1;
        #1;
        check("md_wait1_stall", bus.stall, 1);
        tick();
        check("md_wait2_stall", bus.stall, 1);
        bus.md_done = 1; bus.mw_rd = 5'd7; bus.mw_we = 1;
        #1;
        check("md_done_stall", bus.stall, 0);
        check("md_done_sel_a", bus.sel_a, 2);
        tick();
        bus.md_done = 0; bus.mw_we = 0;
        #1;
        check("md_empty_stall", bus.stall, 0);
        check("md_empty_full", bus.md_full, 0);
        check("md_empty_err", bus.md_err, 0);
        tick();

        // Fill to depth, blocked third start, then start+done together.
        clear_in();
        bus.md_start = 1; bus.md_rd = 5'd8;
        tick();
        bus.md_rd = 5'd9;
        #1;
        check("fill1_full", bus.md_full, 0);
        check("fill1_stall", bus.stall, 0);
        tick();
        bus.md_rd = 5'd10;
        #1;
        check("fill2_full", bus.md_full, 1);
        check("fill3_stall", bus.stall, 1);
        tick();
        bus.md_start = 0; bus.dx_rs1 = 5'd10; bus.dx_use_rs1 = 1;
        #1;
        check("fill3_not_pushed", bus.stall, 0);
        check("fill3_full", bus.md_full, 1);
        bus.dx_use_rs1 = 0;
        bus.md_start = 1; bus.md_rd = 5'd10; bus.md_done = 1; bus.mw_rd = 5'd8; bus.mw_we = 1;
        #1;
        check("pushpop_stall", bus.stall, 0);
        tick();
        clear_in();
        bus.dx_rs1 = 5'd9; bus.dx_use_rs1 = 1;
        #1;
        check("pushpop_full", bus.md_full, 1);
        check("pend9_stall", bus.stall, 1);
        bus.dx_use_rs1 = 0; bus.dx_rs2 = 5'd10; bus.dx_use_rs2 = 1;
        #1;
        check("pend10_stall", bus.stall, 1);
        bus.md_done = 1; bus.mw_rd = 5'd9; bus.mw_we = 1;
        #1;
        check("pend10_head_excl_stall", bus.stall, 1);
        tick();
        bus.mw_rd = 5'd10;
        #1;
        check("drain_stall", bus.stall, 0);
        check("drain_sel_b", bus.sel_b, 2);
        tick();
        clear_in();
        #1;
        check("drain_full", bus.md_full, 0);
        check("drain_err", bus.md_err, 0);

        // Underflow error is sticky; reset clears it and pending entries.
        bus.md_done = 1;
        tick();
        bus.md_done = 0;
        #1;
        check("err_set", bus.md_err, 1);
        tick();
        tick();
        check("err_held", bus.md_err, 1);
        bus.md_start = 1; bus.md_rd = 5'd11;
        tick();
        bus.md_rd = 5'd12;
        tick();
        bus.md_start = 0; bus.dx_rs1 = 5'd11; bus.dx_use_rs1 = 1;
        #1;
        check("prerst_stall", bus.stall, 1);
        check("prerst_full", bus.md_full, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_full", bus.md_full, 0);
        check("rst_err", bus.md_err, 0);

        // Randomised run against the queue model.
        q.delete();
        m_err = 0;
        for (int c = 0; c < 400; c++) begin
            int r1, r2, xr, mr, xs2, e_sa, e_sb, e_dm;
            bit u1, u2, ld, st, done, start, full, e_stall, lu, sfull;
            r1 = $urandom_range(3); r2 = $urandom_range(3);
            u1 = $urandom_range(1); u2 = $urandom_range(1);
            xr = $urandom_range(3); xs2 = $urandom_range(3);
            ld = ($urandom_range(3) == 0); st = ($urandom_range(3) == 0);
            start = ($urandom_range(2) == 0);
            done = (q.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
            mr = (done && q.size() > 0) ? q[0] : int'($urandom_range(3));
            bus.dx_rs1 = 5'(r1); bus.dx_rs2 = 5'(r2);
            bus.dx_use_rs1 = u1; bus.dx_use_rs2 = u2;
            bus.xm_rd = 5'(xr); bus.xm_we = ld | ($urandom_range(1) == 1);
            bus.xm_is_load = ld; bus.xm_is_store = st; bus.xm_rs2 = 5'(xs2);
            bus.mw_rd = 5'(mr); bus.mw_we = done | ($urandom_range(1) == 1);
            bus.md_start = start; bus.md_rd = 5'($urandom_range(3));
            bus.md_done = done;
            #1;
            e_sa = ref_sel(u1, r1, ld);
            e_sb = ref_sel(u2, r2, ld);
            e_dm = (st && bus.mw_we && mr == xs2 && xs2 != 0) ? 1 : 0;
            lu = ld && bus.xm_we &&
                 ((u1 && r1 != 0 && r1 == xr) || (u2 && r2 != 0 && r2 == xr));
            full = (q.size() == DEPTH);
            sfull = start && full && !done;
            e_stall = lu || ref_pend(u1, r1, done) || ref_pend(u2, r2, done) || sfull;
            check("rnd_sel_a", bus.sel_a, e_sa);
            check("rnd_sel_b", bus.sel_b, e_sb);
            check("rnd_dmem_sel", bus.dmem_sel, e_dm);
            check("rnd_stall", bus.stall, e_stall);
            check("rnd_md_full", bus.md_full, full);
            check("rnd_md_err", bus.md_err, m_err);
            if (done && q.size() == 0) m_err = 1;
            if (done && q.size() > 0) void'(q.pop_front());
            if (start && !e_stall) q.push_back(int'(bus.md_rd));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
